// File: rtl/conv_stream_pkg.sv
// Shared types and sizing helpers for the streaming convolution unit.
package conv_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    function automatic int ofm_size(input int ifm, input int k, input int stride);
        return (ifm - k) / stride + 1;
    endfunction

    // Wide enough that summing K*K full-width products can never overflow.
    function automatic int acc_width(input int dw, input int kk);
        return 2 * dw + $clog2(kk);
    endfunction

    // Saturation limits of a dw-bit signed result, sign-extended to aw bits.
    function automatic int sat_pad(input int aw, input int dw);
        return aw - dw + 1;
    endfunction

endpackage

// File: rtl/conv_window_buffer.sv
// Shift-register line buffer exposing the K*K sliding-window taps behind the newest pixel.
module conv_window_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int IFM_SIZE    = 13,
    parameter int KERNAL_SIZE = 5
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  shift_i,
    input  logic [DATA_WIDTH-1:0]                                 pixel_i,
    output logic [KERNAL_SIZE*KERNAL_SIZE-1:0][DATA_WIDTH-1:0]    taps_o
);

    localparam int LEN = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE;

    logic [DATA_WIDTH-1:0] line_q [LEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) line_q[i] <= '0;
        end else if (shift_i) begin
            line_q[0] <= pixel_i;
            for (int i = 1; i < LEN; i++) line_q[i] <= line_q[i-1];
        end
    end

    // Tap (r,c) sits r full rows plus c pixels behind the newest entry.
    genvar gi, gj;
    generate
        for (gi = 0; gi < KERNAL_SIZE; gi++) begin : g_row
            for (gj = 0; gj < KERNAL_SIZE; gj++) begin : g_col
                assign taps_o[gi*KERNAL_SIZE+gj] = line_q[gi*IFM_SIZE+gj];
            end
        end
    endgenerate

endmodule

// File: rtl/conv_stream_unit.sv
// Self-sequenced single-filter convolution: weight memory, window buffer and 3-stage MAC.
// Optional CONV_STREAM_RELU_EN clamps negative results to zero in the output stage.
module conv_stream_unit
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int FRAC_BITS         = 16,
    parameter int IFM_SIZE          = 13,
    parameter int KERNAL_SIZE       = 5,
    parameter int STRIDE            = 1,
    parameter int NUMBER_OF_FILTERS = 28,
    parameter int ADDRESS_SIZE_WM   = $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                riscv_data,
    input  logic                                 wm_enable_write,
    input  logic [ADDRESS_SIZE_WM-1:0]           wm_address,
    input  logic                                 start,
    input  logic [$clog2(NUMBER_OF_FILTERS)-1:0] filter_index,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int KK       = KERNAL_SIZE * KERNAL_SIZE;
    localparam int WM_DEPTH = KK * NUMBER_OF_FILTERS;
    localparam int AW       = acc_width(DATA_WIDTH, KK);
    localparam int PW       = 2 * DATA_WIDTH;
    localparam int CNT_W    = $clog2(KK + 1);
    localparam int POS_W    = $clog2(IFM_SIZE);
    localparam int PAD      = sat_pad(AW, DATA_WIDTH);

    localparam logic [CNT_W-1:0]     KK_C     = CNT_W'(KK);
    localparam logic [CNT_W-1:0]     KK_LAST  = CNT_W'(KK - 1);
    localparam logic [POS_W-1:0]     POS_LAST = POS_W'(IFM_SIZE - 1);
    localparam logic [POS_W-1:0]     K1_C     = POS_W'(KERNAL_SIZE - 1);
    localparam logic [POS_W-1:0]     STRIDE_C = POS_W'(STRIDE);
    localparam logic signed [AW-1:0] SAT_MAX  = {{PAD{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN  = {{PAD{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_e                     state_q, state_d;
    logic [ADDRESS_SIZE_WM-1:0] base_q, base_d;
    logic [CNT_W-1:0]           load_cnt_q, load_cnt_d;
    logic [ADDRESS_SIZE_WM-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]      rd_data_q;
    logic                       rd_pend_q;
    logic [CNT_W-1:0]           rd_idx_q;
    logic [DATA_WIDTH-1:0]      weight_q [KK];
    logic [DATA_WIDTH-1:0]      wm_mem [WM_DEPTH];

    logic [POS_W-1:0]           row_q, col_q;
    logic                       accept, stall, win_hit, last_pix, pipe_empty;
    logic [KK-1:0][DATA_WIDTH-1:0] taps;

    logic signed [PW-1:0]       prod_d [KK];
    logic signed [PW-1:0]       prod_q [KK];
    logic signed [AW-1:0]       sum_d, sum_q, shifted;
    logic [DATA_WIDTH-1:0]      res_d, out_data_q;
    logic                       win_v_q, p1_v_q, p2_v_q, out_valid_q;

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = (state_q == STREAM) && !stall;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign last_pix   = (row_q == POS_LAST) && (col_q == POS_LAST);
    assign pipe_empty = !win_v_q && !p1_v_q && !p2_v_q && !out_valid_q;
    assign win_hit    = (row_q >= K1_C) && (col_q >= K1_C)
                     && (((row_q - K1_C) % STRIDE_C) == '0)
                     && (((col_q - K1_C) % STRIDE_C) == '0);
    assign rd_addr    = base_q + ADDRESS_SIZE_WM'(load_cnt_q);

    // Weight memory: inferred RAM with one-cycle registered read.
    always_ff @(posedge clk) begin
        if (wm_enable_write) wm_mem[wm_address] <= riscv_data;
        rd_data_q <= wm_mem[rd_addr];
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        load_cnt_d = load_cnt_q;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = ADDRESS_SIZE_WM'(filter_index * KK);
                    load_cnt_d = '0;
                    state_d    = LOAD_W;
                end
            end
            LOAD_W: begin
                if (load_cnt_q < KK_C) load_cnt_d = load_cnt_q + 1'b1;
                if (rd_pend_q && (rd_idx_q == KK_LAST)) state_d = STREAM;
            end
            STREAM: begin
                if (accept && last_pix) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            load_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            for (int i = 0; i < KK; i++) weight_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            load_cnt_q <= load_cnt_d;
            rd_pend_q  <= (state_q == LOAD_W) && (load_cnt_q < KK_C);
            rd_idx_q   <= load_cnt_q;
            for (int i = 0; i < KK; i++)
                if (rd_pend_q && (rd_idx_q == CNT_W'(i))) weight_q[i] <= rd_data_q;
            if (state_q == IDLE && start) begin
                row_q <= '0;
                col_q <= '0;
            end else if (accept) begin
                if (col_q == POS_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    conv_window_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .IFM_SIZE    (IFM_SIZE),
        .KERNAL_SIZE (KERNAL_SIZE)
    ) u_window (
        .clk     (clk),
        .rst     (reset),
        .shift_i (accept),
        .pixel_i (in_data),
        .taps_o  (taps)
    );

    // Window index j pairs with weight KK-1-j so weight 0 lands on the top-left tap.
    genvar gi;
    generate
        for (gi = 0; gi < KK; gi++) begin : g_mul
            assign prod_d[gi] = $signed(taps[gi]) * $signed(weight_q[KK-1-gi]);
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < KK; i++)
            sum_d = sum_d + {{(AW-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end

    always_comb begin
        shifted = sum_q >>> FRAC_BITS;
        if (shifted > SAT_MAX)      res_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (shifted < SAT_MIN) res_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                        res_d = shifted[DATA_WIDTH-1:0];
`ifdef CONV_STREAM_RELU_EN
        if (res_d[DATA_WIDTH-1]) res_d = '0;
`else
`endif
    end

    // Whole pipeline freezes while the output register is held by the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_v_q     <= 1'b0;
            p1_v_q      <= 1'b0;
            p2_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < KK; i++) prod_q[i] <= '0;
        end else if (!stall) begin
            win_v_q     <= accept && win_hit;
            p1_v_q      <= win_v_q;
            p2_v_q      <= p1_v_q;
            out_valid_q <= p2_v_q;
            if (win_v_q)
                for (int i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
            if (p1_v_q) sum_q <= sum_d;
            if (p2_v_q) out_data_q <= res_d;
        end
    end

endmodule

// File: tb/tb_conv_stream_unit.sv
// Directed self-checking bench for conv_stream_unit (stride 1 and stride 2 instances).
module tb_conv_stream_unit;

    localparam logic [31:0] ONE     = 32'h0001_0000;
    localparam logic [31:0] BIG     = 32'h7FFF_0000;
    localparam logic [31:0] BIG_NEG = 32'h8001_0000;
`ifdef CONV_STREAM_RELU_EN
    localparam logic [31:0] NEG_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_EXP = 32'h8000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] riscv_data = '0;
    logic        wm_enable_write = 1'b0;
    logic [9:0]  wm_address = '0;
    logic        start = 1'b0;
    logic [4:0]  filter_index = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy, done;

    logic        s2_start = 1'b0;
    logic        s2_in_valid = 1'b0;
    logic        s2_in_ready, s2_out_valid, s2_busy, s2_done;
    logic [31:0] s2_out_data;
    logic        s2_out_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int done_cnt = 0, done2_cnt = 0;
    int first_ov_cyc = 0, acc_cyc = 0;
    bit seen_ov = 0, rnd_ready = 0, stall_prev = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] got[$];
    logic [31:0] got2[$];

    conv_stream_unit u_dut (
        .clk(clk), .reset(reset), .riscv_data(riscv_data), .wm_enable_write(wm_enable_write),
        .wm_address(wm_address), .start(start), .filter_index(filter_index),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    conv_stream_unit #(.STRIDE(2)) u_dut_s2 (
        .clk(clk), .reset(reset), .riscv_data(riscv_data), .wm_enable_write(wm_enable_write),
        .wm_address(wm_address), .start(s2_start), .filter_index(filter_index),
        .in_data(in_data), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
        .out_data(s2_out_data), .out_valid(s2_out_valid), .out_ready(s2_out_ready),
        .busy(s2_busy), .done(s2_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check_eq("stall_valid_held", 64'(out_valid), 64'd1);
                check_eq("stall_data_held", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && !seen_ov) begin
                seen_ov = 1;
                first_ov_cyc = cyc_cnt;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt++;
            if (s2_out_valid && s2_out_ready) got2.push_back(s2_out_data);
            if (s2_done) done2_cnt++;
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic load_filter(input int f, input bit one_hot, input logic [31:0] v);
        for (int i = 0; i < 25; i++) begin
            wm_address      = 10'(f * 25 + i);
            riscv_data      = one_hot ? ((i == 12) ? ONE : 32'h0) : v;
            wm_enable_write = 1'b1;
            tick();
        end
        wm_enable_write = 1'b0;
    endtask

    function automatic logic [31:0] pix(input int mode, input logic [31:0] v, input int idx);
        return (mode == 1) ? 32'(idx << 16) : v;
    endfunction

    task automatic run_job(input int sel, input int filt, input int mode, input logic [31:0] v,
                           input bit rnd, input int npix);
        int idx, n;
        bit acc;
        got.delete();
        got2.delete();
        done_cnt = 0;
        done2_cnt = 0;
        seen_ov = 0;
        rnd_ready = rnd;
        filter_index = 5'(filt);
        if (sel == 1) s2_start = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0;
        s2_start = 1'b0;
        idx = 0;
        n = 0;
        while (idx < npix && n < 4000) begin
            in_data = pix(mode, v, idx);
            // A start mid-stream must be ignored.
            start = (sel == 0 && idx == 100);
            if (sel == 1) s2_in_valid = 1'b1; else in_valid = 1'b1;
            @(negedge clk);
            acc = (sel == 1) ? s2_in_ready : in_ready;
            tick();
            if (acc) begin
                if (idx == 56) acc_cyc = cyc_cnt;
                idx++;
            end
            n++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        s2_in_valid = 1'b0;
        check_eq("pixels_accepted", 64'(idx), 64'(npix));
    endtask

    task automatic finish_job(input int sel);
        int n;
        n = 0;
        while (((sel == 1) ? done2_cnt : done_cnt) == 0 && n < 2000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check_eq("done_once", 64'((sel == 1) ? done2_cnt : done_cnt), 64'd1);
        check_eq("busy_low_after_done", 64'((sel == 1) ? s2_busy : busy), 64'd0);
        rnd_ready = 0;
    endtask

    task automatic check_results(input int sel, input int mode, input logic [31:0] v, input int n_exp);
        int n;
        logic [31:0] g, e;
        n = (sel == 1) ? got2.size() : got.size();
        check_eq("output_count", 64'(n), 64'(n_exp));
        for (int k = 0; k < n && k < n_exp; k++) begin
            g = (sel == 1) ? got2[k] : got[k];
            e = (mode == 1) ? 32'((((k / 9) + 2) * 13 + ((k % 9) + 2)) << 16) : v;
            check_eq("output_value", 64'(g), 64'(e));
        end
        $display("job sel=%0d mode=%0d pixel=%h outputs=%0d", sel, mode, v, n);
    endtask

    initial begin
        repeat (3) tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        load_filter(0, 1'b0, ONE);
        load_filter(3, 1'b0, ONE);
        load_filter(5, 1'b1, 32'h0);
        load_filter(1, 1'b0, BIG);

        // All-ones kernel over all-ones image.
        run_job(0, 3, 0, ONE, 1'b0, 169);
        finish_job(0);
        check_results(0, 0, 32'h0019_0000, 81);

        // Centre one-hot kernel over a ramp image, plus first-result latency.
        run_job(0, 5, 1, 32'h0, 1'b0, 169);
        check_eq("first_out_latency", 64'(first_ov_cyc - acc_cyc), 64'd3);
        finish_job(0);
        check_results(0, 1, 32'h0, 81);

        // Same stream under random backpressure.
        run_job(0, 5, 1, 32'h0, 1'b1, 169);
        finish_job(0);
        check_results(0, 1, 32'h0, 81);

        // Positive and negative saturation.
        run_job(0, 1, 0, BIG, 1'b0, 169);
        finish_job(0);
        check_results(0, 0, 32'h7FFF_FFFF, 81);
        run_job(0, 1, 0, BIG_NEG, 1'b0, 169);
        finish_job(0);
        check_results(0, 0, NEG_EXP, 81);

        // Stride 2 instance.
        run_job(1, 3, 0, ONE, 1'b0, 169);
        finish_job(1);
        check_results(1, 0, 32'h0019_0000, 25);

        // Abort mid-stream, then rerun with the retained weights.
        run_job(0, 0, 0, ONE, 1'b0, 60);
        check_eq("pre_abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("abort_out_valid", 64'(out_valid), 64'd0);
        check_eq("abort_out_data", 64'(out_data), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_in_ready", 64'(in_ready), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        run_job(0, 0, 0, ONE, 1'b0, 169);
        finish_job(0);
        check_results(0, 0, 32'h0019_0000, 81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_stream_unit.md
Name: conv_stream_unit

Overview:
Self-sequenced convolution unit for one filter over one IFM channel, with parametrised kernel size, IFM size and stride. It keeps a weight memory written by the RISC-V. On start it loads the K*K weights of the selected filter into a register bank, then accepts a valid/ready pixel stream in raster order. A sliding-window line buffer feeds a pipelined MAC, which emits one saturated output per valid window position on a valid/ready output. It replaces external FIFO/conv enable sequencing with internal control.

Parameters:
DATA_WIDTH, 32, signed fixed-point width of pixels, weights and outputs
FRAC_BITS, 16, fractional bits of the fixed-point format
IFM_SIZE, 13, IFM width and height
KERNAL_SIZE, 5, kernel width and height (K)
STRIDE, 1, window stride (1 or 2)
NUMBER_OF_FILTERS, 28, filters held in the weight memory
ADDRESS_SIZE_WM, $clog2(K*K*NUMBER_OF_FILTERS), weight memory address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
riscv_data  in  DATA_WIDTH  weight write data
wm_enable_write  in  1  weight memory write strobe
wm_address  in  ADDRESS_SIZE_WM  weight write address
start  in  1  one-cycle start pulse; ignored unless idle
filter_index  in  $clog2(NUMBER_OF_FILTERS)  filter selected; sampled on start
in_data  in  DATA_WIDTH  IFM pixel
in_valid  in  1  pixel valid
in_ready  out  1  unit accepts a pixel
out_data  out  DATA_WIDTH  convolution result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts a result
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset: state IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Pipeline valids, counters and window buffer are cleared. Weight memory contents are not cleared.
- Weight write: WM[wm_address] <= riscv_data on wm_enable_write. A write is allowed in any state, but a write to the active filter during LOAD_W gives undefined results.
- FSM:
  - IDLE: on start, latch base=filter_index*K*K and go to LOAD_W.
  - LOAD_W: issue K*K reads at addresses base..base+K*K-1; read latency is 1 cycle. The data returned for address base+i fills weight register i. After the last fill (K*K+1 cycles) go to STREAM.
  - STREAM: in_ready = !stall. A pixel is accepted on in_valid&&in_ready. After the IFM_SIZE^2-th pixel is accepted, go to DRAIN.
  - DRAIN: in_ready=0; wait until the pipeline is empty and the last out handshake has completed. Then pulse done and go to IDLE.
- Window: the line buffer holds (K-1)*IFM_SIZE+K pixels. Tap (r,c) is the pixel r rows and c columns behind the newest pixel, where r,c are in 0..K-1. Window index j=r*K+c pairs with weight K*K-1-j, so weight 0 is the top-left.
- Window valid on accept of pixel (row,col) when row>=K-1, col>=K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0.
- Output count is OFM^2, where OFM=(IFM_SIZE-K)/STRIDE+1. Defaults give 81.
- MAC pipeline has 3 register stages:
  - S1: K*K signed products, each 2*DATA_WIDTH wide.
  - S2: adder-tree sum into an accumulator of 2*DATA_WIDTH+$clog2(K*K) bits.
  - S3: arithmetic shift right by FRAC_BITS, saturate to the signed DATA_WIDTH range, register into out_data/out_valid.
  - out_valid rises 3 cycles after the accepting clock edge of the completing pixel.
- Backpressure: stall = out_valid && !out_ready. While stalled, all stages hold and in_ready=0. out_data is stable while out_valid && !out_ready.
- Boundaries:
  - start while busy is ignored.
  - in_valid outside STREAM is ignored.
  - Simultaneous out handshake and S2 advance forms a seamless chain, one result per cycle.
  - Column wrap resets col to 0 and increments row.
  - Reset mid-operation aborts immediately with no done pulse.

Optional Feature:
CONV_STREAM_RELU_EN. When defined, S3 clamps negative results to 0 after saturation; latency is unchanged. When undefined, signed results pass through.

Decomposition:
- Shared package conv_stream_pkg holds:
  - state enum (IDLE, LOAD_W, STREAM, DRAIN);
  - a function computing OFM from IFM_SIZE, K and STRIDE;
  - accumulator width and saturation limit constants.
- One natural sub-module: conv_window_buffer. It is a parametrised shift-register line buffer that outputs K*K taps, with shift enable = accepted pixel.

Test Plan:
1. Load filter 3 with all weights 0x00010000 (1.0); start; stream 169 pixels of 1.0 with out_ready=1 -> 81 outputs, each 0x00190000; done pulses once after the 81st; busy falls after done.
2. One-hot kernel: weight 12 (centre) = 1.0, others 0; pixel value = 1.0*(row*13+col) -> output (i,j) = ((i+2)*13+(j+2))<<16; first out_valid 3 cycles after pixel (4,4) is accepted.
3. Random out_ready at 50% duty with in_valid=1 -> no lost or duplicated results; out_data stable while stalled; sequence matches test 1 or 2 golden values.
4. Saturation: weights 0x7FFF0000, pixels 0x7FFF0000 -> every output 0x7FFFFFFF. Negated pixels -> 0x80000000, or 0 when CONV_STREAM_RELU_EN is defined.
5. STRIDE=2, test 1 stimulus -> exactly 25 outputs of 0x00190000; done after the 25th.
6. Assert reset after 60 pixels -> all outputs 0 and state IDLE immediately; a new start with filter 0 then runs cleanly to 81 outputs with weights intact.
